// File: rtl/scoreboard.sv
// In-order instruction window: accepts decoded entries, tags them with trans_id,
// feeds issue in order, collects write-backs by id and retires the oldest completed entry.

package scoreboard_pkg;

    localparam int unsigned NR_SB_ENTRIES = 4;
    localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);
    localparam int unsigned XLEN          = 64;

    localparam logic [XLEN-1:0] ILLEGAL_INSTR = 64'd2;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;

    typedef struct packed {
        logic [XLEN-1:0]          pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [3:0]               fu;
        logic [7:0]               op;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic [XLEN-1:0]          result;
        logic                     valid;
        logic                     use_imm;
        exception_t               ex;
    } scoreboard_entry_t;

endpackage

module scoreboard
    import scoreboard_pkg::*;
#(
    parameter int unsigned NR_ENTRIES  = NR_SB_ENTRIES,
    parameter int unsigned NR_WB_PORTS = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    output logic                     full_o,

    input  scoreboard_entry_t        decoded_instr_i,
    input  logic                     decoded_instr_valid_i,
    output logic                     decoded_instr_ack_o,

    output scoreboard_entry_t        issue_instr_o,
    output logic                     issue_instr_valid_o,
    input  logic                     issue_ack_i,

    input  logic [TRANS_ID_BITS-1:0] trans_id_i [NR_WB_PORTS],
    input  logic [XLEN-1:0]          wdata_i    [NR_WB_PORTS],
    input  exception_t               ex_i       [NR_WB_PORTS],
    input  logic                     wb_valid_i [NR_WB_PORTS],

    output scoreboard_entry_t        commit_instr_o,
    output logic                     commit_valid_o,
    input  logic                     commit_ack_i
);

    localparam int unsigned IDW  = TRANS_ID_BITS;
    localparam int unsigned CNTW = TRANS_ID_BITS + 1;

    scoreboard_entry_t     mem_q [NR_ENTRIES];
    scoreboard_entry_t     mem_d [NR_ENTRIES];
    logic [NR_ENTRIES-1:0] occ_q, occ_d;
    logic [IDW-1:0]        top_q, top_d;
    logic [IDW-1:0]        issue_ptr_q, issue_ptr_d;
    logic [IDW-1:0]        commit_ptr_q, commit_ptr_d;
    logic [CNTW-1:0]       count_q, count_d;
    logic [CNTW-1:0]       issued_q, issued_d;

    logic enq_fire;
    logic issue_fire;
    logic commit_fire;

    // Handshake and presentation logic: registered state plus pointer muxes only
    always_comb begin
        full_o              = (count_q == CNTW'(NR_ENTRIES));
        decoded_instr_ack_o = decoded_instr_valid_i && !full_o;
        issue_instr_valid_o = (issued_q < count_q);
        issue_instr_o       = mem_q[issue_ptr_q];
        commit_instr_o      = mem_q[commit_ptr_q];
        commit_valid_o      = (count_q != '0) && (issued_q != '0) && mem_q[commit_ptr_q].valid;

        enq_fire    = decoded_instr_ack_o && !flush_i;
        issue_fire  = issue_ack_i && issue_instr_valid_o;
        commit_fire = commit_ack_i && commit_valid_o;
    end

    // Next-state: write-back, enqueue, issue, commit; flush overrides everything
    always_comb begin
        mem_d        = mem_q;
        occ_d        = occ_q;
        top_d        = top_q;
        issue_ptr_d  = issue_ptr_q;
        commit_ptr_d = commit_ptr_q;
        count_d      = count_q;
        issued_d     = issued_q;

        if (flush_i) begin
            occ_d        = '0;
            top_d        = '0;
            issue_ptr_d  = '0;
            commit_ptr_d = '0;
            count_d      = '0;
            issued_d     = '0;
            for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
                mem_d[i].valid = 1'b0;
            end
        end else begin
            // Ascending port order lets the highest index win on a shared id
            for (int unsigned k = 0; k < NR_WB_PORTS; k++) begin
                if (wb_valid_i[k] && occ_q[trans_id_i[k]]) begin
                    mem_d[trans_id_i[k]].result = wdata_i[k];
                    mem_d[trans_id_i[k]].valid  = 1'b1;
                    if (ex_i[k].valid) begin
                        mem_d[trans_id_i[k]].ex = ex_i[k];
                    end
                end
            end

            // A decode-time fault makes the entry complete on arrival
            if (enq_fire) begin
                mem_d[top_q]          = decoded_instr_i;
                mem_d[top_q].trans_id = top_q;
                mem_d[top_q].valid    = decoded_instr_i.ex.valid;
                occ_d[top_q]          = 1'b1;
                top_d                 = top_q + IDW'(1);
            end

            if (issue_fire) begin
                issue_ptr_d = issue_ptr_q + IDW'(1);
            end

            if (commit_fire) begin
                occ_d[commit_ptr_q]       = 1'b0;
                mem_d[commit_ptr_q].valid = 1'b0;
                commit_ptr_d              = commit_ptr_q + IDW'(1);
            end

            count_d  = count_q + CNTW'(enq_fire) - CNTW'(commit_fire);
            issued_d = issued_q + CNTW'(issue_fire) - CNTW'(commit_fire);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
            occ_q        <= '0;
            top_q        <= '0;
            issue_ptr_q  <= '0;
            commit_ptr_q <= '0;
            count_q      <= '0;
            issued_q     <= '0;
        end else begin
            for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
                mem_q[i] <= mem_d[i];
            end
            occ_q        <= occ_d;
            top_q        <= top_d;
            issue_ptr_q  <= issue_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            count_q      <= count_d;
            issued_q     <= issued_d;
        end
    end

endmodule

// File: tb/tb_scoreboard.sv
// Directed bench for scoreboard: commit stream checked by a queue-based monitor,
// handshake/status outputs checked inline by the stimulus.

module tb_scoreboard;
    import scoreboard_pkg::*;

    localparam int unsigned NP = 3;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic                     rst_ni;
    logic                     flush_i;
    logic                     full_o;
    scoreboard_entry_t        decoded_instr_i;
    logic                     decoded_instr_valid_i;
    logic                     decoded_instr_ack_o;
    scoreboard_entry_t        issue_instr_o;
    logic                     issue_instr_valid_o;
    logic                     issue_ack_i;
    logic [TRANS_ID_BITS-1:0] trans_id_i [NP];
    logic [XLEN-1:0]          wdata_i    [NP];
    exception_t               ex_i       [NP];
    logic                     wb_valid_i [NP];
    scoreboard_entry_t        commit_instr_o;
    logic                     commit_valid_o;
    logic                     commit_ack_i;

    typedef struct {
        logic [TRANS_ID_BITS-1:0] id;
        logic [4:0]               rd;
        logic [63:0]              res;
        logic                     exv;
        logic [63:0]              cause;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    scoreboard #(.NR_ENTRIES(NR_SB_ENTRIES), .NR_WB_PORTS(NP)) dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .flush_i               (flush_i),
        .full_o                (full_o),
        .decoded_instr_i       (decoded_instr_i),
        .decoded_instr_valid_i (decoded_instr_valid_i),
        .decoded_instr_ack_o   (decoded_instr_ack_o),
        .issue_instr_o         (issue_instr_o),
        .issue_instr_valid_o   (issue_instr_valid_o),
        .issue_ack_i           (issue_ack_i),
        .trans_id_i            (trans_id_i),
        .wdata_i               (wdata_i),
        .ex_i                  (ex_i),
        .wb_valid_i            (wb_valid_i),
        .commit_instr_o        (commit_instr_o),
        .commit_valid_o        (commit_valid_o),
        .commit_ack_i          (commit_ack_i)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic scoreboard_entry_t mk(input logic [4:0] rd, input logic exv,
                                             input logic [63:0] cause);
        scoreboard_entry_t e;
        e          = '0;
        e.pc       = 64'h1000 + 64'(rd) * 64'd4;
        e.rd       = rd;
        e.fu       = 4'd3;
        e.ex.valid = exv;
        e.ex.cause = cause;
        if (exv) e.ex.tval = e.pc;
        return e;
    endfunction

    task automatic idle();
        decoded_instr_valid_i = 1'b0;
        decoded_instr_i       = '0;
        issue_ack_i           = 1'b0;
        commit_ack_i          = 1'b0;
        flush_i               = 1'b0;
        for (int k = 0; k < int'(NP); k++) begin
            wb_valid_i[k] = 1'b0;
            trans_id_i[k] = '0;
            wdata_i[k]    = '0;
            ex_i[k]       = '0;
        end
    endtask

    task automatic enq(input logic [4:0] rd, input logic exv, input logic [63:0] cause);
        decoded_instr_valid_i = 1'b1;
        decoded_instr_i       = mk(rd, exv, cause);
    endtask

    task automatic wb(input int port, input logic [TRANS_ID_BITS-1:0] id, input logic [63:0] d);
        wb_valid_i[port] = 1'b1;
        trans_id_i[port] = id;
        wdata_i[port]    = d;
    endtask

    task automatic expect_commit(input logic [TRANS_ID_BITS-1:0] id, input logic [4:0] rd,
                                 input logic [63:0] res, input logic exv, input logic [63:0] cause);
        exp_t e;
        e.id = id; e.rd = rd; e.res = res; e.exv = exv; e.cause = cause;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Commit monitor: every retirement handshake is matched against the queue
    always @(negedge clk_i) begin
        if (rst_ni && commit_ack_i && commit_valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_commit: got id %0d expected none", commit_instr_o.trans_id);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("commit_id",     64'(commit_instr_o.trans_id), 64'(e.id));
                chk("commit_rd",     64'(commit_instr_o.rd),       64'(e.rd));
                chk("commit_result", commit_instr_o.result,        e.res);
                chk("commit_exv",    64'(commit_instr_o.ex.valid), 64'(e.exv));
                chk("commit_cause",  commit_instr_o.ex.cause,      e.cause);
            end
        end
    end

    initial begin
        idle();
        rst_ni = 1'b0;

        // Reset state
        #12;
        decoded_instr_valid_i = 1'b1;
        #1;
        chk("rst_full",         64'(full_o), 64'd0);
        chk("rst_issue_valid",  64'(issue_instr_valid_o), 64'd0);
        chk("rst_commit_valid", 64'(commit_valid_o), 64'd0);
        chk("rst_issue_zero",   64'(issue_instr_o == '0), 64'd1);
        chk("rst_commit_zero",  64'(commit_instr_o == '0), 64'd1);
        chk("rst_ack_follows1", 64'(decoded_instr_ack_o), 64'd1);
        decoded_instr_valid_i = 1'b0;
        #1;
        chk("rst_ack_follows0", 64'(decoded_instr_ack_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();

        // Fill the window: rd 1..4 take ids 0..3
        for (int i = 0; i < 4; i++) begin
            idle(); enq(5'(i + 1), 1'b0, 64'd0);
            @(negedge clk_i);
            chk("fill_ack",  64'(decoded_instr_ack_o), 64'd1);
            chk("fill_full", 64'(full_o), 64'd0);
            step();
        end
        idle(); enq(5'd5, 1'b0, 64'd0);
        @(negedge clk_i);
        chk("full_after_4", 64'(full_o), 64'd1);
        chk("fifth_refused", 64'(decoded_instr_ack_o), 64'd0);
        chk("issue_valid_full", 64'(issue_instr_valid_o), 64'd1);
        step();

        // Issue all four in order
        for (int i = 0; i < 4; i++) begin
            idle(); issue_ack_i = 1'b1;
            @(negedge clk_i);
            chk("issue_valid", 64'(issue_instr_valid_o), 64'd1);
            chk("issue_id",    64'(issue_instr_o.trans_id), 64'(i));
            chk("issue_rd",    64'(issue_instr_o.rd), 64'(i + 1));
            step();
        end
        idle();
        @(negedge clk_i);
        chk("issue_drained", 64'(issue_instr_valid_o), 64'd0);
        chk("no_commit_unwritten", 64'(commit_valid_o), 64'd0);
        step();

        // Write back ids 2 and 0
        idle(); wb(0, 2'd2, 64'hAA); wb(1, 2'd0, 64'hBB);
        @(negedge clk_i);
        chk("commit_before_wb_edge", 64'(commit_valid_o), 64'd0);
        step();

        // Commit id 0 while offering an enqueue into the full window
        idle(); commit_ack_i = 1'b1; enq(5'd5, 1'b0, 64'd0);
        expect_commit(2'd0, 5'd1, 64'hBB, 1'b0, 64'd0);
        @(negedge clk_i);
        chk("commit_valid_id0", 64'(commit_valid_o), 64'd1);
        chk("enq_blocked_same_cycle", 64'(decoded_instr_ack_o), 64'd0);
        chk("full_during_commit", 64'(full_o), 64'd1);
        step();

        idle(); enq(5'd5, 1'b0, 64'd0);
        @(negedge clk_i);
        chk("enq_after_commit", 64'(decoded_instr_ack_o), 64'd1);
        chk("full_cleared", 64'(full_o), 64'd0);
        chk("head_id1_waits", 64'(commit_valid_o), 64'd0);
        chk("head_is_id1", 64'(commit_instr_o.trans_id), 64'd1);
        step();

        idle();
        @(negedge clk_i);
        chk("full_again", 64'(full_o), 64'd1);
        chk("wrap_issue_valid", 64'(issue_instr_valid_o), 64'd1);
        chk("wrap_issue_id", 64'(issue_instr_o.trans_id), 64'd0);
        chk("wrap_issue_rd", 64'(issue_instr_o.rd), 64'd5);
        step();

        // Two ports hit id 1: port 2 wins
        idle(); wb(0, 2'd1, 64'h11); wb(2, 2'd1, 64'h22);
        step();
        idle(); commit_ack_i = 1'b1;
        expect_commit(2'd1, 5'd2, 64'h22, 1'b0, 64'd0);
        @(negedge clk_i);
        chk("commit_valid_id1", 64'(commit_valid_o), 64'd1);
        step();
        idle(); commit_ack_i = 1'b1;
        expect_commit(2'd2, 5'd3, 64'hAA, 1'b0, 64'd0);
        @(negedge clk_i);
        chk("commit_valid_id2", 64'(commit_valid_o), 64'd1);
        step();

        // Write-back to unoccupied id 2 is ignored; id 3 completes
        idle(); wb(0, 2'd2, 64'hDEAD); wb(1, 2'd3, 64'h33);
        @(negedge clk_i);
        chk("head_id3_waits", 64'(commit_valid_o), 64'd0);
        step();
        idle(); commit_ack_i = 1'b1;
        expect_commit(2'd3, 5'd4, 64'h33, 1'b0, 64'd0);
        @(negedge clk_i);
        chk("commit_valid_id3", 64'(commit_valid_o), 64'd1);
        step();

        // Decode-faulting entry alongside normal traffic
        idle(); issue_ack_i = 1'b1; enq(5'd6, 1'b1, ILLEGAL_INSTR);
        @(negedge clk_i);
        chk("fault_enq_ack", 64'(decoded_instr_ack_o), 64'd1);
        chk("issue_id0_wrap", 64'(issue_instr_o.trans_id), 64'd0);
        chk("unissued_no_commit", 64'(commit_valid_o), 64'd0);
        step();
        idle(); issue_ack_i = 1'b1; wb(2, 2'd0, 64'h55);
        @(negedge clk_i);
        chk("fault_issue_id", 64'(issue_instr_o.trans_id), 64'd1);
        chk("fault_issue_exv", 64'(issue_instr_o.ex.valid), 64'd1);
        chk("head_id0_waits", 64'(commit_valid_o), 64'd0);
        step();
        idle(); commit_ack_i = 1'b1;
        expect_commit(2'd0, 5'd5, 64'h55, 1'b0, 64'd0);
        @(negedge clk_i);
        chk("commit_valid_id0b", 64'(commit_valid_o), 64'd1);
        step();
        idle(); commit_ack_i = 1'b1;
        expect_commit(2'd1, 5'd6, 64'd0, 1'b1, ILLEGAL_INSTR);
        @(negedge clk_i);
        chk("fault_commit_no_wb", 64'(commit_valid_o), 64'd1);
        step();

        // Minimum latency: enqueue faulting at N, issue at N+1, commit valid after N+1
        idle(); enq(5'd7, 1'b1, ILLEGAL_INSTR);
        step();
        idle(); issue_ack_i = 1'b1;
        @(negedge clk_i);
        chk("minlat_issue_valid", 64'(issue_instr_valid_o), 64'd1);
        chk("minlat_issue_id", 64'(issue_instr_o.trans_id), 64'd2);
        chk("minlat_not_yet", 64'(commit_valid_o), 64'd0);
        step();
        idle(); commit_ack_i = 1'b1;
        expect_commit(2'd2, 5'd7, 64'd0, 1'b1, ILLEGAL_INSTR);
        @(negedge clk_i);
        chk("minlat_commit_valid", 64'(commit_valid_o), 64'd1);
        step();

        // Three in flight, then flush with an enqueue offer
        idle(); enq(5'd8, 1'b0, 64'd0);
        step();
        idle(); enq(5'd9, 1'b0, 64'd0); issue_ack_i = 1'b1;
        @(negedge clk_i);
        chk("preflush_issue_id", 64'(issue_instr_o.trans_id), 64'd3);
        step();
        idle(); enq(5'd10, 1'b0, 64'd0);
        step();
        idle(); flush_i = 1'b1; enq(5'd11, 1'b0, 64'd0);
        @(negedge clk_i);
        chk("flush_cycle_ack", 64'(decoded_instr_ack_o), 64'd1);
        step();
        idle();
        @(negedge clk_i);
        chk("postflush_full", 64'(full_o), 64'd0);
        chk("postflush_issue_valid", 64'(issue_instr_valid_o), 64'd0);
        chk("postflush_commit_valid", 64'(commit_valid_o), 64'd0);
        step();
        idle(); enq(5'd12, 1'b0, 64'd0);
        @(negedge clk_i);
        chk("postflush_enq_ack", 64'(decoded_instr_ack_o), 64'd1);
        step();
        idle();
        @(negedge clk_i);
        chk("postflush_issue_id", 64'(issue_instr_o.trans_id), 64'd0);
        chk("postflush_issue_rd", 64'(issue_instr_o.rd), 64'd12);
        step();

        // Asynchronous reset between clock edges
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_issue_valid", 64'(issue_instr_valid_o), 64'd0);
        chk("async_rst_full", 64'(full_o), 64'd0);
        chk("async_rst_issue_zero", 64'(issue_instr_o == '0), 64'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        idle(); enq(5'd14, 1'b0, 64'd0);
        @(negedge clk_i);
        chk("postrst_enq_ack", 64'(decoded_instr_ack_o), 64'd1);
        step();
        idle();
        @(negedge clk_i);
        chk("postrst_issue_id", 64'(issue_instr_o.trans_id), 64'd0);
        chk("postrst_issue_rd", 64'(issue_instr_o.rd), 64'd14);
        step();

        repeat (3) step();
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
